// File: rtl/mult_controller_pkg.sv
// Shared ALU control codes and multiplier FSM state encoding.
package mult_controller_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MUL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_datapath.sv
// Radix-2 shift-add multiplier datapath; one partial-product step per step_i.
// Signed operands are supported only when MULT_SIGNED_EN is defined.
module mult_datapath
  import mult_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               sign_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] prod_nxt_o
);

  logic [WIDTH-1:0]   mcand_q, mpl_q, acc_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   acc_nxt, mpl_nxt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_raw;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Multiply magnitudes; the most-negative value is its own magnitude as unsigned.
  always_comb begin
    a_mag = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;
    neg_d = sign_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset)       neg_q <= 1'b0;
    else if (load_i) neg_q <= neg_d;
  end

  assign prod_nxt_o = neg_q ? -prod_raw : prod_raw;
`else
  logic sign_unused;
  assign sign_unused = sign_i;
  assign a_mag       = a_i;
  assign b_mag       = b_i;
  assign prod_nxt_o  = prod_raw;
`endif

  // Add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign sum      = {1'b0, acc_q} + {1'b0, (mpl_q[0] ? mcand_q : '0)};
  assign acc_nxt  = sum[WIDTH:1];
  assign mpl_nxt  = {sum[0], mpl_q[WIDTH-1:1]};
  assign prod_raw = {acc_nxt, mpl_nxt};

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      mpl_q   <= '0;
      acc_q   <= '0;
    end else if (load_i) begin
      mcand_q <= a_mag;
      mpl_q   <= b_mag;
      acc_q   <= '0;
    end else if (step_i) begin
      acc_q   <= acc_nxt;
      mpl_q   <= mpl_nxt;
    end
  end

endmodule

// File: rtl/mult_controller.sv
// Multi-cycle multiply controller: FSM, iteration counter, pipeline stall handshake.
// Optional signed multiply enabled with MULT_SIGNED_EN.
module mult_controller
  import mult_controller_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               req, load, step, last;

  assign req  = start && (alucontrol == MUL_CODE);
  assign last = (state_q == S_RUN) && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = req ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
    load  = ((state_q == S_IDLE) || (state_q == S_DONE)) && req;
    step  = busy;
    stall = load || busy;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load)      cnt_d = CW'(WIDTH);
    else if (step) cnt_d = cnt_q - CW'(1);
  end

  // Result registers only move on the final step, so they hold across IDLE/RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (last) {hi_q, lo_q} <= prod_nxt;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .step_i     (step),
    .sign_i     (sign),
    .a_i        (a),
    .b_i        (b),
    .prod_nxt_o (prod_nxt)
  );

endmodule

// File: tb/tb_mult_controller.sv
// Directed-vector bench for mult_controller (expectations follow MULT_SIGNED_EN).
module tb_mult_controller;
  import mult_controller_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, sign;
  logic [3:0]   alucontrol;
  logic [W-1:0] a, b;
  logic         busy, done, stall;
  logic [W-1:0] lo, hi;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vs;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  mult_controller #(.WIDTH(W), .MUL_CODE(ALU_MUL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .sign       (sign),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .lo         (lo),
    .hi         (hi)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n, nbusy;
    bit both;
    start = 1'b1; alucontrol = ALU_MUL; a = v.va; b = v.vb; sign = v.vs;
    #1;
    chk({nm, "_stall_req"}, 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    n = 0; nbusy = 0; both = 1'b0;
    while (!done && n < 100) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    both = busy && done;
    chk({nm, "_latency"}, 64'(n), 64'd32);
    chk({nm, "_busy_cycles"}, 64'(nbusy), 64'd32);
    chk({nm, "_busy_and_done"}, 64'(both), 64'd0);
    chk({nm, "_stall_in_done"}, 64'(stall), 64'd0);
    chk({nm, "_hi"}, 64'(hi), 64'(v.ehi));
    chk({nm, "_lo"}, 64'(lo), 64'(v.elo));
    tick();
    chk({nm, "_done_pulse"}, 64'({done, busy}), 64'd0);
    chk({nm, "_hold"}, {hi, lo}, {v.ehi, v.elo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, m;
    bit seen;

    vecs[0] = '{32'd3,        32'd5,        1'b0, 32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000};
    vecs[7] = '{32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{32'hFFFF_FFFF, 32'd2,        1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
`ifdef MULT_SIGNED_EN
    vecs[2] = '{32'hFFFF_FFFE, 32'd3,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[4] = '{32'h8000_0000, 32'd1,        1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
    vecs[9] = '{32'd7,        32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
`else
    vecs[2] = '{32'hFFFF_FFFE, 32'd3,        1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[4] = '{32'h8000_0000, 32'd1,        1'b1, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[9] = '{32'd7,        32'hFFFF_FFFF, 1'b1, 32'h0000_0006, 32'hFFFF_FFF9};
`endif

    reset = 1'b1; start = 1'b0; alucontrol = 4'b0000; a = '0; b = '0; sign = 1'b0;
    tick();
    tick();
    chk("reset_state", {59'd0, busy, done, stall, (hi != 0), (lo != 0)}, 64'd0);

    // reset wins over a simultaneous request
    start = 1'b1; alucontrol = ALU_MUL; a = 32'd3; b = 32'd5;
    tick();
    chk("reset_priority_busy", 64'(busy), 64'd0);
    start = 1'b0; reset = 1'b0;
    tick();

    start = 1'b1; alucontrol = ALU_ADD; a = 32'd3; b = 32'd5;
    #1;
    chk("wrong_code_stall", 64'(stall), 64'd0);
    repeat (3) tick();
    chk("wrong_code_busy", 64'({busy, done, stall}), 64'd0);
    start = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abandon an operation at RUN cycle 10
    start = 1'b1; alucontrol = ALU_MUL; a = 32'd3; b = 32'd5; sign = 1'b0;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("midrun_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_reset_state", {busy, done, hi, lo}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("midrun_no_done", 64'(seen), 64'd0);

    // back-to-back with an ignored mid-RUN request
    start = 1'b1; alucontrol = ALU_MUL; a = 32'd11; b = 32'd13;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 5) begin
        start = 1'b1; a = 32'd99; b = 32'd99;
        #1;
        chk("b2b_stall_in_run", 64'(stall), 64'd1);
      end
      if (n == 6) start = 1'b0;
      tick();
      n++;
    end
    chk("b2b_first_latency", 64'(n), 64'd32);
    chk("b2b_first_result", {hi, lo}, 64'd143);
    start = 1'b1; a = 32'd7; b = 32'd6;
    #1;
    chk("b2b_stall_in_done", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    chk("b2b_straight_to_run", 64'({busy, done}), 64'b10);
    m = 1;
    while (!done && m < 100) begin
      tick();
      m++;
    end
    chk("b2b_second_gap", 64'(m), 64'd33);
    chk("b2b_second_result", {hi, lo}, 64'd42);
    tick();
    chk("b2b_done_pulse", 64'({busy, done}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
